matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter IDX_W, 15, row/column index width; one matrix-address index field.
REQ-002 SHALL have parameter DATA_W, 32, element, accumulator and config width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports, one per line (name, direction, width, meaning):
- wishbone_clk_i  in  1  clock.
- wishbone_rst_i  in  1  synchronous active-high reset.
- start  in  1  one-cycle go pulse from register 5.
- abort  in  1  cancel the running job.
- cfg_op  in  DATA_W  operation: 1 = C=A*B, 2 = C=A+B.
- cfg_wa, cfg_ha, cfg_wb, cfg_hb  in  DATA_W each  dimensions (element counts).
- a_rd_en, b_rd_en  out  1  read strobes.
- a_addr, b_addr  out  2*IDX_W  {row, col}.
- a_rd_data, b_rd_data  in  DATA_W  valid exactly 1 cycle after strobe.
- c_wr_en  out  1  write strobe.
- c_addr  out  2*IDX_W  {row, col}.
- c_wr_data  out  DATA_W  result.
- busy  out  1  job active.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky config error.

Function
REQ-005 SHALL accept start only in IDLE; start while busy is ignored; config is latched into shadow registers on acceptance.
REQ-006 SHALL use states IDLE, CHECK, RUN, DRAIN, WRITE, DONE, ERR.
REQ-007 Transitions:
- IDLE -> CHECK on start.
- CHECK -> RUN if config is valid, else -> ERR.
- RUN -> DRAIN after the last k is issued.
- DRAIN -> WRITE.
- WRITE -> RUN, or -> DONE after the last element.
- DONE and ERR -> IDLE after one cycle.
REQ-008 Config SHALL be valid when all of the following hold:
- cfg_op is 1 or 2.
- Each dimension lies in 1..2^IDX_W.
- For op 1: wa == hb.
- For op 2: wa == wb and ha == hb.
REQ-009 Op 1 SHALL compute C[i][j] = sum over k of A[i][k]*B[k][j]. K = wa; i < ha; j < wb.
REQ-010 Op 2 SHALL compute C[i][j] = A[i][j] + B[i][j], with K = 1.
REQ-011 Traversal SHALL be row-major over (i, j), with k innermost.
REQ-012 RUN SHALL issue one read pair per cycle; the accumulator adds the returned product (op 1) or sum (op 2) one cycle later.
REQ-013 The accumulator SHALL clear at entry to each element's first RUN cycle.
REQ-014 Each element SHALL take K+2 cycles (K RUN, 1 DRAIN, 1 WRITE). c_wr_en SHALL be high only in WRITE, carrying the accumulator.
REQ-015 Arithmetic SHALL be unsigned, with products and sums truncated modulo 2^DATA_W; no saturation and no overflow flag.
REQ-016 Start accepted at cycle 0 SHALL give CHECK at cycle 1, first RUN at cycle 2, and done at cycle 2 + ha*wb*(K+2) for op 1 (ha*wa*(K+2) for op 2).
REQ-017 busy SHALL be high from CHECK through DONE/ERR inclusive.
REQ-018 ERR SHALL pulse done, set error and issue no reads or writes. error SHALL clear on the next accepted start.
REQ-019 abort SHALL take effect as follows:
- In any non-IDLE state: next state is IDLE, no further c_wr_en, no done pulse.
- abort together with start in IDLE: abort wins.
REQ-020 Index counters SHALL wrap to 0 at dimension-1 without overflow at dimension 2^IDX_W.

Reset
REQ-021 On wishbone_rst_i: state SHALL be IDLE; busy, done, error, a_rd_en, b_rd_en and c_wr_en SHALL be 0; addresses, c_wr_data, accumulator and shadow config SHALL be 0.
REQ-022 Reset mid-job SHALL discard all progress; no write occurs in the reset cycle.

Structure
REQ-023 Shared package ai_accel_pkg SHALL hold IDX_W, DATA_W, the op codes (OP_MUL=1, OP_ADD=2) and the state enum.
REQ-024 The multiply/add-accumulate datapath SHALL be sub-module ai_mac (clear, enable, op select, a, b -> acc). All other logic is in matmul_sequencer.

Verification
REQ-025 Op 1, 2x2 multiply:
- Stimulus: A=[[1,2],[3,4]], B=[[5,6],[7,8]].
- Required: C=[[19,22],[43,50]]; four c_wr_en pulses; done at cycle 18.
REQ-026 Op 2, 1x3 add:
- Stimulus: A=[1,2,0xFFFFFFFF], B=[4,5,1].
- Required: C=[5,7,0] (wrap); done at cycle 11.
REQ-027 Op 1, invalid dimensions:
- Stimulus: wa=3, hb=4.
- Required: ERR; done at cycle 2 with error=1; no reads or writes; next valid start clears error.
REQ-028 Op 1, 15x15 with A[i][j]=i*j, B[i][j]=i*(j+1)/2:
- Required: C matches a golden model.
- Required: done at cycle 2 + 225*17 = 3827.
REQ-029 Abort, start-while-busy and reset:
- abort at cycle 5 of a 2x2 job: idle next cycle, no done, at most one C write.
- start while busy: ignored.
- reset in RUN: all outputs at reset values the next cycle.

Source files
------------

// File: rtl/ai_accel_pkg.sv
// Shared definitions for the AI accelerator blocks: widths, operation codes,
// sequencer states and a dimension range helper.
package ai_accel_pkg;

  localparam int unsigned IDX_W  = 15;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned OP_MUL = 1;
  localparam int unsigned OP_ADD = 2;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RUN,
    DRAIN,
    WRITE,
    DONE,
    ERR
  } state_t;

  // A dimension is usable when it lies in 1..2^idx_w.
  function automatic logic dim_ok(input logic [63:0] dim, input int unsigned idx_w);
    return (dim != '0) && (dim <= (64'd1 << idx_w));
  endfunction

endpackage

// File: rtl/ai_mac.sv
// Multiply/add-accumulate datapath: each enabled cycle adds a*b or a+b into acc,
// truncated modulo 2^DATA_W.
module ai_mac #(
  parameter int unsigned DATA_W = ai_accel_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              op_add,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] term;

  always_comb begin
    term = op_add ? (a + b) : (a * b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + term;
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Matrix multiply / add sequencer: walks C row-major with k innermost, issues one
// A/B read pair per RUN cycle and writes each accumulated element in WRITE.
module matmul_sequencer #(
  parameter int unsigned IDX_W  = ai_accel_pkg::IDX_W,
  parameter int unsigned DATA_W = ai_accel_pkg::DATA_W
) (
  input  logic                 wishbone_clk_i,
  input  logic                 wishbone_rst_i,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DATA_W-1:0]    cfg_op,
  input  logic [DATA_W-1:0]    cfg_wa,
  input  logic [DATA_W-1:0]    cfg_ha,
  input  logic [DATA_W-1:0]    cfg_wb,
  input  logic [DATA_W-1:0]    cfg_hb,
  output logic                 a_rd_en,
  output logic                 b_rd_en,
  output logic [2*IDX_W-1:0]   a_addr,
  output logic [2*IDX_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]    a_rd_data,
  input  logic [DATA_W-1:0]    b_rd_data,
  output logic                 c_wr_en,
  output logic [2*IDX_W-1:0]   c_addr,
  output logic [DATA_W-1:0]    c_wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  import ai_accel_pkg::*;

  state_t state, state_nxt;

  logic [DATA_W-1:0] sh_op, sh_wa, sh_ha, sh_wb, sh_hb;
  logic [IDX_W-1:0]  idx_i, idx_j, idx_k;
  logic [IDX_W-1:0]  lim_i, lim_j, lim_k;
  logic [IDX_W-1:0]  col_a, row_b;
  logic              op_mul, op_add, cfg_ok, accept;
  logic              last_i, last_j, last_k;
  logic              rd_valid, mac_clear, mac_en;
  logic [DATA_W-1:0] acc;

  always_comb begin
    op_mul = (sh_op == DATA_W'(OP_MUL));
    op_add = (sh_op == DATA_W'(OP_ADD));
    accept = (state == IDLE) && start && !abort;

    cfg_ok = dim_ok(64'(sh_wa), IDX_W) && dim_ok(64'(sh_ha), IDX_W) &&
             dim_ok(64'(sh_wb), IDX_W) && dim_ok(64'(sh_hb), IDX_W);
    if (op_mul) begin
      cfg_ok = cfg_ok && (sh_wa == sh_hb);
    end else if (op_add) begin
      cfg_ok = cfg_ok && (sh_wa == sh_wb) && (sh_ha == sh_hb);
    end else begin
      cfg_ok = 1'b0;
    end

    // Limits are dimension-1, so a dimension of 2^IDX_W still fits the counters.
    lim_k  = op_mul ? IDX_W'(sh_wa - DATA_W'(1)) : '0;
    lim_i  = IDX_W'(sh_ha - DATA_W'(1));
    lim_j  = IDX_W'(sh_wb - DATA_W'(1));
    last_k = (idx_k == lim_k);
    last_j = (idx_j == lim_j);
    last_i = (idx_i == lim_i);

    col_a  = op_mul ? idx_k : idx_j;
    row_b  = op_mul ? idx_k : idx_i;
  end

  always_ff @(posedge wishbone_clk_i) begin
    if (wishbone_rst_i) begin
      state    <= IDLE;
      sh_op    <= '0;
      sh_wa    <= '0;
      sh_ha    <= '0;
      sh_wb    <= '0;
      sh_hb    <= '0;
      idx_i    <= '0;
      idx_j    <= '0;
      idx_k    <= '0;
      error    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= (state == RUN);

      if (accept) begin
        sh_op <= cfg_op;
        sh_wa <= cfg_wa;
        sh_ha <= cfg_ha;
        sh_wb <= cfg_wb;
        sh_hb <= cfg_hb;
        idx_i <= '0;
        idx_j <= '0;
        idx_k <= '0;
        error <= 1'b0;
      end else if ((state == CHECK) && !cfg_ok && !abort) begin
        error <= 1'b1;
      end

      if (state == RUN) begin
        idx_k <= last_k ? '0 : idx_k + IDX_W'(1);
      end

      if (state == WRITE) begin
        if (last_j) begin
          idx_j <= '0;
          idx_i <= last_i ? '0 : idx_i + IDX_W'(1);
        end else begin
          idx_j <= idx_j + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = CHECK;
      CHECK:   state_nxt = cfg_ok ? RUN : ERR;
      RUN:     if (last_k) state_nxt = DRAIN;
      DRAIN:   state_nxt = WRITE;
      WRITE:   state_nxt = (last_i && last_j) ? DONE : RUN;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
    end

    busy      = (state != IDLE);
    done      = (state == DONE) || (state == ERR);
    a_rd_en   = (state == RUN);
    b_rd_en   = (state == RUN);
    c_wr_en   = (state == WRITE) && !wishbone_rst_i;
    a_addr    = {idx_i, col_a};
    b_addr    = {row_b, idx_j};
    c_addr    = {idx_i, idx_j};
    c_wr_data = acc;

    // Read data returns one cycle after the strobe, so the add trails the issue.
    mac_clear = (state == RUN) && (idx_k == '0);
    mac_en    = rd_valid && ((state == RUN) || (state == DRAIN));
  end

  ai_mac #(
    .DATA_W(DATA_W)
  ) u_mac (
    .clk    (wishbone_clk_i),
    .rst    (wishbone_rst_i),
    .clear  (mac_clear),
    .en     (mac_en),
    .op_add (op_add),
    .a      (a_rd_data),
    .b      (b_rd_data),
    .acc    (acc)
  );

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: directed and random jobs compared
// against a loop-based matrix reference model and the cycle-count formula.
module tb_matmul_sequencer;

  localparam int unsigned IDX_W  = 15;
  localparam int unsigned DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst, start, abort;
  logic [DATA_W-1:0]   cfg_op, cfg_wa, cfg_ha, cfg_wb, cfg_hb;
  logic                a_rd_en, b_rd_en, c_wr_en, busy, done, error;
  logic [2*IDX_W-1:0]  a_addr, b_addr, c_addr;
  logic [DATA_W-1:0]   a_rd_data, b_rd_data, c_wr_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_a [16][16];
  logic [31:0] mem_b [16][16];

  logic               a_pend = 1'b0, b_pend = 1'b0;
  logic [2*IDX_W-1:0] a_paddr = '0, b_paddr = '0;

  always #5 clk = ~clk;

  matmul_sequencer #(
    .IDX_W (IDX_W),
    .DATA_W(DATA_W)
  ) dut (
    .wishbone_clk_i(clk),
    .wishbone_rst_i(rst),
    .start         (start),
    .abort         (abort),
    .cfg_op        (cfg_op),
    .cfg_wa        (cfg_wa),
    .cfg_ha        (cfg_ha),
    .cfg_wb        (cfg_wb),
    .cfg_hb        (cfg_hb),
    .a_rd_en       (a_rd_en),
    .b_rd_en       (b_rd_en),
    .a_addr        (a_addr),
    .b_addr        (b_addr),
    .a_rd_data     (a_rd_data),
    .b_rd_data     (b_rd_data),
    .c_wr_en       (c_wr_en),
    .c_addr        (c_addr),
    .c_wr_data     (c_wr_data),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  function automatic logic [31:0] fetch(input bit is_b, input logic [2*IDX_W-1:0] ad);
    int unsigned r, c;
    r = ad[2*IDX_W-1:IDX_W];
    c = ad[IDX_W-1:0];
    if (r < 16 && c < 16) return is_b ? mem_b[r][c] : mem_a[r][c];
    return 32'hBAD0_0000;
  endfunction

  // Memory responder: data for a strobe appears in the following cycle, junk otherwise.
  always @(negedge clk) begin
    a_rd_data = (a_pend === 1'b1) ? fetch(1'b0, a_paddr) : $urandom;
    b_rd_data = (b_pend === 1'b1) ? fetch(1'b1, b_paddr) : $urandom;
    a_pend    = a_rd_en;
    b_pend    = b_rd_en;
    a_paddr   = a_addr;
    b_paddr   = b_addr;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] d);
    return (d >= 1) && (d <= 32'd32768);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".busy"},      64'(busy),      64'd0);
    check_eq({tag, ".done"},      64'(done),      64'd0);
    check_eq({tag, ".error"},     64'(error),     64'd0);
    check_eq({tag, ".rd_en"},     64'({a_rd_en, b_rd_en}), 64'd0);
    check_eq({tag, ".c_wr_en"},   64'(c_wr_en),   64'd0);
    check_eq({tag, ".addrs"},     64'(a_addr | b_addr | c_addr), 64'd0);
    check_eq({tag, ".c_wr_data"}, 64'(c_wr_data), 64'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        mem_a[i][j] = $urandom;
        mem_b[i][j] = $urandom;
      end
  endtask

  task automatic load_2x2();
    mem_a[0][0] = 1; mem_a[0][1] = 2; mem_a[1][0] = 3; mem_a[1][1] = 4;
    mem_b[0][0] = 5; mem_b[0][1] = 6; mem_b[1][0] = 7; mem_b[1][1] = 8;
  endtask

  task automatic run_job(input string name, input logic [31:0] op, input logic [31:0] wa,
                         input logic [31:0] ha, input logic [31:0] wb, input logic [31:0] hb,
                         input int poke);
    logic [61:0]  exp_q[$];
    logic [61:0]  got_q[$];
    bit           valid;
    int unsigned  rows, cols, kk, exp_done, done_cyc, n_rd, busy_lo;
    logic [31:0]  s;
    logic         err_done;

    valid = ((op == 1) || (op == 2)) && in_rng(wa) && in_rng(ha) && in_rng(wb) && in_rng(hb);
    if (op == 1) valid = valid && (wa == hb);
    if (op == 2) valid = valid && (wa == wb) && (ha == hb);

    rows = ha; cols = (op == 1) ? wb : wa; kk = (op == 1) ? wa : 1;
    if (valid) begin
      for (int unsigned i = 0; i < rows; i++)
        for (int unsigned j = 0; j < cols; j++) begin
          s = '0;
          if (op == 1) begin
            for (int unsigned k = 0; k < kk; k++) s = s + mem_a[i][k] * mem_b[k][j];
          end else begin
            s = mem_a[i][j] + mem_b[i][j];
          end
          exp_q.push_back({15'(i), 15'(j), s});
        end
      exp_done = 2 + rows * cols * (kk + 2);
    end else begin
      exp_done = 2;
    end

    @(negedge clk);
    cfg_op = op; cfg_wa = wa; cfg_ha = ha; cfg_wb = wb; cfg_hb = hb;
    start = 1'b1;
    @(negedge clk);
    done_cyc = 0; n_rd = 0; busy_lo = 0; err_done = 1'bx;
    for (int c = 1; c <= int'(exp_done) + 20; c++) begin
      start = (c == poke);
      if (c == poke) begin
        cfg_op = $urandom; cfg_wa = $urandom; cfg_ha = $urandom;
        cfg_wb = $urandom; cfg_hb = $urandom;
      end
      if (c == 1) check_eq({name, ".err_cleared"}, 64'(error), 64'd0);
      if (c_wr_en) got_q.push_back({c_addr, c_wr_data});
      if (a_rd_en || b_rd_en) n_rd++;
      if (!busy) busy_lo++;
      if (done) begin
        done_cyc = c;
        err_done = error;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;

    check_eq({name, ".done_cyc"}, 64'(done_cyc), 64'(exp_done));
    check_eq({name, ".error"},    64'(err_done), 64'(!valid));
    check_eq({name, ".busy_lo"},  64'(busy_lo),  64'd0);
    check_eq({name, ".wr_cnt"},   64'(got_q.size()), 64'(exp_q.size()));
    if (!valid) check_eq({name, ".reads"}, 64'(n_rd), 64'd0);
    for (int n = 0; n < exp_q.size() && n < got_q.size(); n++)
      check_eq($sformatf("%s.c%0d", name, n), 64'(got_q[n]), 64'(exp_q[n]));

    @(negedge clk);
    check_eq({name, ".idle_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] op, wa, ha, wb, hb;
    int          wr_cnt, done_seen;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_op = '0; cfg_wa = '0; cfg_ha = '0; cfg_wb = '0; cfg_hb = '0;
    fill_random();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    load_2x2();
    run_job("mul2x2", 1, 2, 2, 2, 2, 0);

    mem_a[0][0] = 1; mem_a[0][1] = 2; mem_a[0][2] = 32'hFFFF_FFFF;
    mem_b[0][0] = 4; mem_b[0][1] = 5; mem_b[0][2] = 1;
    run_job("add1x3", 2, 3, 1, 3, 1, 0);

    run_job("bad_dims", 1, 3, 2, 2, 4, 0);
    run_job("after_err", 1, 1, 1, 1, 1, 0);
    run_job("bad_op", 3, 2, 2, 2, 2, 0);
    run_job("zero_dim", 2, 0, 1, 0, 1, 0);
    run_job("over_dim", 2, 32769, 1, 32769, 1, 0);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        mem_a[i][j] = i * j;
        mem_b[i][j] = (i * (j + 1)) / 2;
      end
    run_job("mul15", 1, 15, 15, 15, 15, 0);

    load_2x2();
    run_job("start_busy", 1, 2, 2, 2, 2, 4);

    for (int r = 0; r < 8; r++) begin
      fill_random();
      op = $urandom_range(1, 2);
      ha = $urandom_range(1, 4); wa = $urandom_range(1, 4); wb = $urandom_range(1, 4);
      if (op == 1) hb = wa;
      else begin wb = wa; hb = ha; end
      if ($urandom_range(0, 3) == 0) hb = hb + 1;
      run_job($sformatf("rand%0d", r), op, wa, ha, wb, hb, (r % 2 == 1) ? 3 : 0);
    end

    // Abort during a 2x2 job at cycle 5.
    load_2x2();
    @(negedge clk);
    cfg_op = 1; cfg_wa = 2; cfg_ha = 2; cfg_wb = 2; cfg_hb = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_cnt = 0; done_seen = 0;
    for (int c = 1; c <= 25; c++) begin
      abort = (c == 5);
      if (c_wr_en) wr_cnt++;
      if (done) done_seen++;
      if (c == 6) check_eq("abort.busy_next", 64'(busy), 64'd0);
      @(negedge clk);
    end
    abort = 1'b0;
    check_eq("abort.done_seen", 64'(done_seen), 64'd0);
    check_eq("abort.wr_le1", 64'(wr_cnt <= 1), 64'd1);

    // Abort together with start in IDLE.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("abort_start.busy", 64'(busy), 64'd0);

    // Reset while in RUN of the second element, with a nonzero accumulator.
    @(negedge clk);
    cfg_op = 1; cfg_wa = 2; cfg_ha = 2; cfg_wb = 2; cfg_hb = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("pre_reset.acc", 64'(c_wr_data), 64'd19);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_reset.busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
